// File: rtl/iq_age_sched.sv
// Oldest-first issue scheduler for a small issue queue: tracks occupancy, operand
// readiness, FU class and relative age (age matrix), and picks one entry per cycle.
module iq_age_sched #(
    parameter  int DEPTH  = 4,
    parameter  int PREG_W = 7,
    parameter  int ROB_W  = 3,
    parameter  int NUM_FU = 8,
    localparam int IDX_W  = $clog2(DEPTH),
    localparam int FU_W   = $clog2(NUM_FU),
    localparam int OCC_W  = IDX_W + 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  alloc_valid,
    output logic                  alloc_ready,
    output logic [IDX_W-1:0]      alloc_idx,
    input  logic [FU_W-1:0]       alloc_fu_sel,
    input  logic [ROB_W-1:0]      alloc_rob_idx,
    input  logic [PREG_W-1:0]     alloc_prs1,
    input  logic [PREG_W-1:0]     alloc_prs2,
    input  logic                  alloc_rs1_rdy,
    input  logic                  alloc_rs2_rdy,
    input  logic                  wb_valid,
    input  logic [PREG_W-1:0]     wb_rd,
    input  logic [NUM_FU-1:0]     fu_ready,
    output logic                  issue_valid,
    input  logic                  issue_ready,
    output logic [IDX_W-1:0]      issue_idx,
    output logic [ROB_W-1:0]      issue_rob_idx,
    input  logic                  mispredict,
    input  logic [2**ROB_W-1:0]   flush_mask,
    output logic [OCC_W-1:0]      occupancy
);

    // Handshakes: a dispatch transfers when alloc_valid && alloc_ready, an issue
    // transfers when issue_valid && issue_ready; both commit at the same rising edge.
    // Neither ready/valid output depends on the partner's valid/ready input.

    logic [DEPTH-1:0]  r_valid;
    logic [DEPTH-1:0]  r_rs1_rdy;
    logic [DEPTH-1:0]  r_rs2_rdy;
    logic [PREG_W-1:0] r_prs1    [DEPTH];
    logic [PREG_W-1:0] r_prs2    [DEPTH];
    logic [FU_W-1:0]   r_fu_sel  [DEPTH];
    logic [ROB_W-1:0]  r_rob_idx [DEPTH];
    logic [DEPTH-1:0]  r_age     [DEPTH];

    logic [DEPTH-1:0]  w_wk1;
    logic [DEPTH-1:0]  w_wk2;
    logic              w_wk_a1;
    logic              w_wk_a2;
    logic [DEPTH-1:0]  w_req;
    logic [DEPTH-1:0]  w_grant;
    logic [IDX_W-1:0]  w_grant_idx;
    logic [IDX_W-1:0]  w_alloc_idx;
    logic              w_has_free;
    logic              w_alloc_fire;
    logic              w_issue_fire;
    logic [OCC_W-1:0]  w_occ;

    // Physical register 0 is hard-wired ready and must never act as a wakeup tag.
    function automatic logic wk(input logic v, input logic [PREG_W-1:0] rd,
                                input logic [PREG_W-1:0] p);
        return v && (rd == p) && (rd != '0);
    endfunction

    always_comb begin
        w_wk_a1 = wk(wb_valid, wb_rd, alloc_prs1);
        w_wk_a2 = wk(wb_valid, wb_rd, alloc_prs2);
        w_wk1   = '0;
        w_wk2   = '0;
        w_req   = '0;
        for (int i = 0; i < DEPTH; i++) begin
            w_wk1[i] = wk(wb_valid, wb_rd, r_prs1[i]);
            w_wk2[i] = wk(wb_valid, wb_rd, r_prs2[i]);
            w_req[i] = r_valid[i] && (r_rs1_rdy[i] || w_wk1[i])
                       && (r_rs2_rdy[i] || w_wk2[i]) && fu_ready[r_fu_sel[i]];
        end
    end

    // An entry wins unless some other requester is older than it.
    always_comb begin
        w_grant     = '0;
        w_grant_idx = '0;
        for (int i = 0; i < DEPTH; i++) begin
            w_grant[i] = w_req[i];
            for (int j = 0; j < DEPTH; j++) begin
                if (j != i && w_req[j] && r_age[j][i]) begin
                    w_grant[i] = 1'b0;
                end
            end
        end
        for (int i = 0; i < DEPTH; i++) begin
            if (w_grant[i]) begin
                w_grant_idx = IDX_W'(i);
            end
        end
    end

    always_comb begin
        w_alloc_idx = '0;
        w_has_free  = 1'b0;
        for (int i = DEPTH - 1; i >= 0; i--) begin
            if (!r_valid[i]) begin
                w_alloc_idx = IDX_W'(i);
                w_has_free  = 1'b1;
            end
        end
    end

    always_comb begin
        w_occ = '0;
        for (int i = 0; i < DEPTH; i++) begin
            w_occ = w_occ + OCC_W'(r_valid[i]);
        end
    end

    assign alloc_ready   = w_has_free && !mispredict;
    assign alloc_idx     = w_alloc_idx;
    assign issue_valid   = (|w_grant) && !mispredict;
    assign issue_idx     = issue_valid ? w_grant_idx : '0;
    assign issue_rob_idx = issue_valid ? r_rob_idx[w_grant_idx] : '0;
    assign occupancy     = w_occ;
    assign w_alloc_fire  = alloc_valid && alloc_ready;
    assign w_issue_fire  = issue_valid && issue_ready;

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_valid   <= '0;
            r_rs1_rdy <= '0;
            r_rs2_rdy <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                r_prs1[i]    <= '0;
                r_prs2[i]    <= '0;
                r_fu_sel[i]  <= '0;
                r_rob_idx[i] <= '0;
                r_age[i]     <= '0;
            end
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                if (r_valid[i] && w_wk1[i]) r_rs1_rdy[i] <= 1'b1;
                if (r_valid[i] && w_wk2[i]) r_rs2_rdy[i] <= 1'b1;
                if (mispredict && flush_mask[r_rob_idx[i]]) r_valid[i] <= 1'b0;
            end
            if (w_issue_fire) begin
                r_valid[w_grant_idx] <= 1'b0;
            end
            // The new entry is younger than everything currently resident.
            if (w_alloc_fire) begin
                r_valid[w_alloc_idx]   <= 1'b1;
                r_rs1_rdy[w_alloc_idx] <= alloc_rs1_rdy || w_wk_a1;
                r_rs2_rdy[w_alloc_idx] <= alloc_rs2_rdy || w_wk_a2;
                r_prs1[w_alloc_idx]    <= alloc_prs1;
                r_prs2[w_alloc_idx]    <= alloc_prs2;
                r_fu_sel[w_alloc_idx]  <= alloc_fu_sel;
                r_rob_idx[w_alloc_idx] <= alloc_rob_idx;
                r_age[w_alloc_idx]     <= '0;
                for (int j = 0; j < DEPTH; j++) begin
                    if (IDX_W'(j) != w_alloc_idx) begin
                        r_age[j][w_alloc_idx] <= r_valid[j];
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_iq_age_sched.sv
// Directed bench for iq_age_sched. Each check compares
// obs = {occupancy, alloc_ready, alloc_idx, issue_valid, issue_idx, issue_rob_idx}.
module tb_iq_age_sched;

    logic       clk = 1'b0;
    logic       rst;
    logic       alloc_valid;
    logic       alloc_ready;
    logic [1:0] alloc_idx;
    logic [2:0] alloc_fu_sel;
    logic [2:0] alloc_rob_idx;
    logic [6:0] alloc_prs1;
    logic [6:0] alloc_prs2;
    logic       alloc_rs1_rdy;
    logic       alloc_rs2_rdy;
    logic       wb_valid;
    logic [6:0] wb_rd;
    logic [7:0] fu_ready;
    logic       issue_valid;
    logic       issue_ready;
    logic [1:0] issue_idx;
    logic [2:0] issue_rob_idx;
    logic       mispredict;
    logic [7:0] flush_mask;
    logic [2:0] occupancy;

    logic [11:0] obs;
    logic [11:0] exp;
    int n_vec = 0;
    int n_err = 0;

    assign obs = {occupancy, alloc_ready, alloc_idx, issue_valid, issue_idx, issue_rob_idx};

    always #5 clk = ~clk;

    iq_age_sched dut (
        .clk(clk), .rst(rst),
        .alloc_valid(alloc_valid), .alloc_ready(alloc_ready), .alloc_idx(alloc_idx),
        .alloc_fu_sel(alloc_fu_sel), .alloc_rob_idx(alloc_rob_idx),
        .alloc_prs1(alloc_prs1), .alloc_prs2(alloc_prs2),
        .alloc_rs1_rdy(alloc_rs1_rdy), .alloc_rs2_rdy(alloc_rs2_rdy),
        .wb_valid(wb_valid), .wb_rd(wb_rd), .fu_ready(fu_ready),
        .issue_valid(issue_valid), .issue_ready(issue_ready),
        .issue_idx(issue_idx), .issue_rob_idx(issue_rob_idx),
        .mispredict(mispredict), .flush_mask(flush_mask), .occupancy(occupancy)
    );

    task automatic next_cycle;
        @(posedge clk);
        #1;
        alloc_valid = 1'b0;
        wb_valid    = 1'b0;
        wb_rd       = '0;
        mispredict  = 1'b0;
        flush_mask  = '0;
    endtask

    task automatic drive_alloc(input logic [2:0] fu, input logic [2:0] rob,
                               input logic [6:0] p1, input logic r1,
                               input logic [6:0] p2, input logic r2);
        alloc_valid   = 1'b1;
        alloc_fu_sel  = fu;
        alloc_rob_idx = rob;
        alloc_prs1    = p1;
        alloc_rs1_rdy = r1;
        alloc_prs2    = p2;
        alloc_rs2_rdy = r2;
    endtask

    task automatic drive_wb(input logic [6:0] rd);
        wb_valid = 1'b1;
        wb_rd    = rd;
    endtask

    task automatic test_reset;
        rst = 1'b0;
        next_cycle();
        next_cycle();
        rst = 1'b1;
        #1;
        exp = {3'd0, 1'b1, 2'd0, 1'b0, 2'd0, 3'd0}; n_vec++;
        if (obs !== exp) begin n_err++; $display("FAIL reset: obs=%h exp=%h", obs, exp); end
    endtask

    task automatic test_basic_order;
        issue_ready = 1'b0;
        drive_alloc(3'd0, 3'd1, 7'd0, 1'b1, 7'd0, 1'b1); #1;
        exp = {3'd0, 1'b1, 2'd0, 1'b0, 2'd0, 3'd0}; n_vec++;
        if (obs !== exp) begin n_err++; $display("FAIL basic_c1: obs=%h exp=%h", obs, exp); end
        next_cycle();
        drive_alloc(3'd0, 3'd2, 7'd0, 1'b1, 7'd0, 1'b1); #1;
        exp = {3'd1, 1'b1, 2'd1, 1'b1, 2'd0, 3'd1}; n_vec++;
        if (obs !== exp) begin n_err++; $display("FAIL basic_c2: obs=%h exp=%h", obs, exp); end
        next_cycle();
        issue_ready = 1'b1; #1;
        exp = {3'd2, 1'b1, 2'd2, 1'b1, 2'd0, 3'd1}; n_vec++;
        if (obs !== exp) begin n_err++; $display("FAIL basic_c3: obs=%h exp=%h", obs, exp); end
        next_cycle(); #1;
        exp = {3'd1, 1'b1, 2'd0, 1'b1, 2'd1, 3'd2}; n_vec++;
        if (obs !== exp) begin n_err++; $display("FAIL basic_c4: obs=%h exp=%h", obs, exp); end
        next_cycle(); #1;
        exp = {3'd0, 1'b1, 2'd0, 1'b0, 2'd0, 3'd0}; n_vec++;
        if (obs !== exp) begin n_err++; $display("FAIL basic_c5: obs=%h exp=%h", obs, exp); end
    endtask

    task automatic test_back_to_back;
        issue_ready = 1'b0;
        drive_alloc(3'd0, 3'd3, 7'd0, 1'b1, 7'd0, 1'b1);
        next_cycle();
        issue_ready = 1'b1;
        drive_alloc(3'd0, 3'd4, 7'd0, 1'b1, 7'd0, 1'b1); #1;
        exp = {3'd1, 1'b1, 2'd1, 1'b1, 2'd0, 3'd3}; n_vec++;
        if (obs !== exp) begin n_err++; $display("FAIL b2b_both: obs=%h exp=%h", obs, exp); end
        next_cycle(); #1;
        exp = {3'd1, 1'b1, 2'd0, 1'b1, 2'd1, 3'd4}; n_vec++;
        if (obs !== exp) begin n_err++; $display("FAIL b2b_next: obs=%h exp=%h", obs, exp); end
        next_cycle(); #1;
        exp = {3'd0, 1'b1, 2'd0, 1'b0, 2'd0, 3'd0}; n_vec++;
        if (obs !== exp) begin n_err++; $display("FAIL b2b_empty: obs=%h exp=%h", obs, exp); end
    endtask

    task automatic test_fill_reuse;
        issue_ready = 1'b0;
        drive_alloc(3'd0, 3'd0, 7'h10, 1'b0, 7'd0, 1'b1);
        next_cycle();
        drive_alloc(3'd0, 3'd1, 7'd0, 1'b1, 7'd0, 1'b1);
        next_cycle();
        drive_alloc(3'd0, 3'd2, 7'h10, 1'b0, 7'd0, 1'b1); #1;
        exp = {3'd2, 1'b1, 2'd2, 1'b1, 2'd1, 3'd1}; n_vec++;
        if (obs !== exp) begin n_err++; $display("FAIL fill_c3: obs=%h exp=%h", obs, exp); end
        next_cycle();
        drive_alloc(3'd0, 3'd3, 7'h10, 1'b0, 7'd0, 1'b1);
        next_cycle();
        issue_ready = 1'b1;
        drive_alloc(3'd0, 3'd6, 7'd0, 1'b1, 7'd0, 1'b1); #1;
        exp = {3'd4, 1'b0, 2'd0, 1'b1, 2'd1, 3'd1}; n_vec++;
        if (obs !== exp) begin n_err++; $display("FAIL fill_full: obs=%h exp=%h", obs, exp); end
        next_cycle();
        issue_ready = 1'b0;
        drive_alloc(3'd0, 3'd5, 7'h10, 1'b0, 7'd0, 1'b1); #1;
        exp = {3'd3, 1'b1, 2'd1, 1'b0, 2'd0, 3'd0}; n_vec++;
        if (obs !== exp) begin n_err++; $display("FAIL fill_reuse: obs=%h exp=%h", obs, exp); end
        next_cycle();
        issue_ready = 1'b1;
        drive_wb(7'h10); #1;
        exp = {3'd4, 1'b0, 2'd0, 1'b1, 2'd0, 3'd0}; n_vec++;
        if (obs !== exp) begin n_err++; $display("FAIL fill_age0: obs=%h exp=%h", obs, exp); end
        next_cycle(); #1;
        exp = {3'd3, 1'b1, 2'd0, 1'b1, 2'd2, 3'd2}; n_vec++;
        if (obs !== exp) begin n_err++; $display("FAIL fill_age2: obs=%h exp=%h", obs, exp); end
        next_cycle(); #1;
        exp = {3'd2, 1'b1, 2'd0, 1'b1, 2'd3, 3'd3}; n_vec++;
        if (obs !== exp) begin n_err++; $display("FAIL fill_age3: obs=%h exp=%h", obs, exp); end
        next_cycle(); #1;
        exp = {3'd1, 1'b1, 2'd0, 1'b1, 2'd1, 3'd5}; n_vec++;
        if (obs !== exp) begin n_err++; $display("FAIL fill_youngest: obs=%h exp=%h", obs, exp); end
        next_cycle(); #1;
        exp = {3'd0, 1'b1, 2'd0, 1'b0, 2'd0, 3'd0}; n_vec++;
        if (obs !== exp) begin n_err++; $display("FAIL fill_empty: obs=%h exp=%h", obs, exp); end
    endtask

    task automatic test_wakeup;
        issue_ready = 1'b0;
        drive_alloc(3'd0, 3'd6, 7'h30, 1'b0, 7'd0, 1'b1);
        next_cycle();
        drive_alloc(3'd0, 3'd1, 7'h25, 1'b0, 7'd0, 1'b1);
        next_cycle();
        issue_ready = 1'b1;
        mispredict  = 1'b1;
        flush_mask  = 8'h40;
        drive_alloc(3'd0, 3'd7, 7'd0, 1'b1, 7'd0, 1'b1); #1;
        exp = {3'd2, 1'b0, 2'd2, 1'b0, 2'd0, 3'd0}; n_vec++;
        if (obs !== exp) begin n_err++; $display("FAIL wk_flush: obs=%h exp=%h", obs, exp); end
        next_cycle();
        drive_alloc(3'd0, 3'd2, 7'h25, 1'b0, 7'd0, 1'b1); #1;
        exp = {3'd1, 1'b1, 2'd0, 1'b0, 2'd0, 3'd0}; n_vec++;
        if (obs !== exp) begin n_err++; $display("FAIL wk_realloc: obs=%h exp=%h", obs, exp); end
        next_cycle();
        drive_wb(7'h25); #1;
        exp = {3'd2, 1'b1, 2'd2, 1'b1, 2'd1, 3'd1}; n_vec++;
        if (obs !== exp) begin n_err++; $display("FAIL wk_same_cycle: obs=%h exp=%h", obs, exp); end
        next_cycle(); #1;
        exp = {3'd1, 1'b1, 2'd1, 1'b1, 2'd0, 3'd2}; n_vec++;
        if (obs !== exp) begin n_err++; $display("FAIL wk_younger: obs=%h exp=%h", obs, exp); end
        next_cycle();
    endtask

    task automatic test_fu_block;
        issue_ready = 1'b0;
        fu_ready    = 8'hFB;
        drive_alloc(3'd2, 3'd3, 7'd0, 1'b1, 7'd0, 1'b1);
        next_cycle();
        drive_alloc(3'd0, 3'd4, 7'd0, 1'b1, 7'd0, 1'b1); #1;
        exp = {3'd1, 1'b1, 2'd1, 1'b0, 2'd0, 3'd0}; n_vec++;
        if (obs !== exp) begin n_err++; $display("FAIL fu_blocked: obs=%h exp=%h", obs, exp); end
        next_cycle();
        issue_ready = 1'b1; #1;
        exp = {3'd2, 1'b1, 2'd2, 1'b1, 2'd1, 3'd4}; n_vec++;
        if (obs !== exp) begin n_err++; $display("FAIL fu_younger: obs=%h exp=%h", obs, exp); end
        next_cycle();
        fu_ready = 8'hFF; #1;
        exp = {3'd1, 1'b1, 2'd1, 1'b1, 2'd0, 3'd3}; n_vec++;
        if (obs !== exp) begin n_err++; $display("FAIL fu_older: obs=%h exp=%h", obs, exp); end
        next_cycle();
    endtask

    task automatic test_flush;
        issue_ready = 1'b1;
        drive_alloc(3'd0, 3'd3, 7'h40, 1'b0, 7'd0, 1'b1);
        next_cycle();
        drive_alloc(3'd0, 3'd4, 7'h40, 1'b0, 7'd0, 1'b1);
        next_cycle();
        drive_alloc(3'd0, 3'd5, 7'h40, 1'b0, 7'd0, 1'b1);
        next_cycle();
        mispredict = 1'b1;
        flush_mask = 8'b0011_0000;
        drive_wb(7'h40);
        drive_alloc(3'd0, 3'd6, 7'd0, 1'b1, 7'd0, 1'b1); #1;
        exp = {3'd3, 1'b0, 2'd3, 1'b0, 2'd0, 3'd0}; n_vec++;
        if (obs !== exp) begin n_err++; $display("FAIL flush_cycle: obs=%h exp=%h", obs, exp); end
        next_cycle(); #1;
        exp = {3'd1, 1'b1, 2'd1, 1'b1, 2'd0, 3'd3}; n_vec++;
        if (obs !== exp) begin n_err++; $display("FAIL flush_survivor: obs=%h exp=%h", obs, exp); end
        next_cycle(); #1;
        exp = {3'd0, 1'b1, 2'd0, 1'b0, 2'd0, 3'd0}; n_vec++;
        if (obs !== exp) begin n_err++; $display("FAIL flush_empty: obs=%h exp=%h", obs, exp); end
    endtask

    task automatic test_zero_reg_and_reset;
        issue_ready = 1'b1;
        drive_alloc(3'd0, 3'd7, 7'd0, 1'b0, 7'd0, 1'b1);
        next_cycle();
        drive_wb(7'd0); #1;
        exp = {3'd1, 1'b1, 2'd1, 1'b0, 2'd0, 3'd0}; n_vec++;
        if (obs !== exp) begin n_err++; $display("FAIL p0_no_wake: obs=%h exp=%h", obs, exp); end
        next_cycle(); #1;
        exp = {3'd1, 1'b1, 2'd1, 1'b0, 2'd0, 3'd0}; n_vec++;
        if (obs !== exp) begin n_err++; $display("FAIL p0_still_wait: obs=%h exp=%h", obs, exp); end
        for (int k = 1; k <= 3; k++) begin
            drive_alloc(3'd0, 3'(k), 7'h50, 1'b0, 7'd0, 1'b1);
            next_cycle();
        end
        #1;
        exp = {3'd4, 1'b0, 2'd0, 1'b0, 2'd0, 3'd0}; n_vec++;
        if (obs !== exp) begin n_err++; $display("FAIL rst_full: obs=%h exp=%h", obs, exp); end
        rst = 1'b0;
        drive_wb(7'h50);
        drive_alloc(3'd0, 3'd6, 7'd0, 1'b1, 7'd0, 1'b1);
        next_cycle();
        rst = 1'b1; #1;
        exp = {3'd0, 1'b1, 2'd0, 1'b0, 2'd0, 3'd0}; n_vec++;
        if (obs !== exp) begin n_err++; $display("FAIL rst_mid: obs=%h exp=%h", obs, exp); end
    endtask

    initial begin
        rst           = 1'b0;
        alloc_valid   = 1'b0;
        alloc_fu_sel  = '0;
        alloc_rob_idx = '0;
        alloc_prs1    = '0;
        alloc_prs2    = '0;
        alloc_rs1_rdy = 1'b0;
        alloc_rs2_rdy = 1'b0;
        wb_valid      = 1'b0;
        wb_rd         = '0;
        fu_ready      = 8'hFF;
        issue_ready   = 1'b0;
        mispredict    = 1'b0;
        flush_mask    = '0;
        test_reset();
        test_basic_order();
        next_cycle();
        test_back_to_back();
        next_cycle();
        test_fill_reuse();
        next_cycle();
        test_wakeup();
        test_fu_block();
        test_flush();
        next_cycle();
        test_zero_reg_and_reset();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
